// File: rtl/branch_predictor_table.sv
// branch_predictor_table: table of saturating direction counters,
// indexed by PC optionally XOR-folded with global history (gshare).
module branch_predictor_table #(
   parameter int IDX_W  = 6,
   parameter int CTR_W  = 2,
   parameter int HIST_W = 4,
   parameter int PC_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             ready,
   input  logic             req_valid,
   input  logic [PC_W-1:0]  req_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int N = 1 << IDX_W;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic             ready_q;
   logic [CTR_W-1:0] tbl_q [N];

   logic             pv_q;
   logic             pt_q;
   logic [IDX_W-1:0] pidx_q;

   logic             req_acc;
   logic             upd_acc;
   logic [IDX_W-1:0] hist_ext;
   logic [IDX_W-1:0] req_idx;
   logic [CTR_W-1:0] ctr_cur;
   logic [CTR_W-1:0] ctr_d;
   logic             unused_pc;

   // Only the word-aligned index bits of the PC select an entry.
   assign unused_pc = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0]};

   assign req_acc = req_valid & ready_q;
   assign upd_acc = upd_valid & ready_q;
   assign req_idx = req_pc[IDX_W+1:2] ^ hist_ext;

   assign ready      = ready_q;
   assign pred_valid = pv_q;
   assign pred_taken = pt_q;
   assign pred_idx   = pidx_q;

   generate
      if (HIST_W == 0) begin : g_nohist
         assign hist_ext = '0;
      end else begin : g_hist
         logic [HIST_W-1:0] hist_q;
         logic [HIST_W-1:0] hist_d;

         // Shift the resolved direction in at the LSB; the cast
         // keeps this valid for a one-bit history as well.
         assign hist_d   = HIST_W'({hist_q, upd_taken});
         assign hist_ext = IDX_W'(hist_q);

         // Non-speculative global history, advanced only by updates.
         always_ff @(posedge clk) begin
            if (reset) begin
               hist_q <= '0;
            end else if (upd_acc) begin
               hist_q <= hist_d;
            end
         end
      end
   endgenerate

   // Saturating next value for the counter being updated.
   always_comb begin
      ctr_cur = tbl_q[upd_idx];
      ctr_d   = ctr_cur;
      if (upd_taken && (ctr_cur != '1)) begin
         ctr_d = ctr_cur + CTR_W'(1);
      end else if (!upd_taken && (ctr_cur != '0)) begin
         ctr_d = ctr_cur - CTR_W'(1);
      end
   end

   // Init sequencer: one entry per cycle, then run until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_INIT: begin
               ptr_q <= ptr_q + IDX_W'(1);
               if (ptr_q == IDX_W'(N - 1)) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_RUN: begin
               state_q <= S_RUN;
            end
            default: begin
               state_q <= S_INIT;
            end
         endcase
      end
   end

   // Counter storage: init writes strongly-taken, run applies updates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == S_INIT) begin
            tbl_q[ptr_q] <= '1;
         end else if (upd_acc) begin
            tbl_q[upd_idx] <= ctr_d;
         end
      end
   end

   // Prediction register reads the pre-update counter and history.
   always_ff @(posedge clk) begin
      if (reset) begin
         pv_q   <= 1'b0;
         pt_q   <= 1'b0;
         pidx_q <= '0;
      end else begin
         pv_q <= req_acc;
         if (req_acc) begin
            pt_q   <= tbl_q[req_idx][CTR_W-1];
            pidx_q <= req_idx;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: scoreboard bench over three table
// configurations (gshare, bimodal, wide-counter).
module tb_branch_predictor_table;

   typedef struct packed {
      logic       t;
      logic [3:0] idx;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        rv   [3];
   logic [31:0] rpc  [3];
   logic        uv   [3];
   logic [3:0]  uidx [3];
   logic        ut   [3];
   logic        rdy  [3];
   logic        pv   [3];
   logic        pt   [3];
   logic [3:0]  pidx0;
   logic [3:0]  pidx1;
   logic [2:0]  pidx2;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int checks = 0;
   int errors = 0;

   branch_predictor_table #(
      .IDX_W(4), .CTR_W(2), .HIST_W(4), .PC_W(32)
   ) u_gs (
      .clk(clk), .reset(reset), .ready(rdy[0]),
      .req_valid(rv[0]), .req_pc(rpc[0]),
      .pred_valid(pv[0]), .pred_taken(pt[0]),
      .pred_idx(pidx0),
      .upd_valid(uv[0]), .upd_idx(uidx[0]),
      .upd_taken(ut[0])
   );

   branch_predictor_table #(
      .IDX_W(4), .CTR_W(2), .HIST_W(0), .PC_W(32)
   ) u_bi (
      .clk(clk), .reset(reset), .ready(rdy[1]),
      .req_valid(rv[1]), .req_pc(rpc[1]),
      .pred_valid(pv[1]), .pred_taken(pt[1]),
      .pred_idx(pidx1),
      .upd_valid(uv[1]), .upd_idx(uidx[1]),
      .upd_taken(ut[1])
   );

   branch_predictor_table #(
      .IDX_W(3), .CTR_W(3), .HIST_W(0), .PC_W(32)
   ) u_wc (
      .clk(clk), .reset(reset), .ready(rdy[2]),
      .req_valid(rv[2]), .req_pc(rpc[2]),
      .pred_valid(pv[2]), .pred_taken(pt[2]),
      .pred_idx(pidx2),
      .upd_valid(uv[2]), .upd_idx(uidx[2][2:0]),
      .upd_taken(ut[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic req(int u, logic [31:0] pc, logic t,
                      logic [3:0] idx);
      exp_t e;
      e.t   = t;
      e.idx = idx;
      rv[u]  = 1'b1;
      rpc[u] = pc;
      case (u)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic upd(int u, logic [3:0] idx, logic t);
      uv[u]   = 1'b1;
      uidx[u] = idx;
      ut[u]   = t;
   endtask

   task automatic mon(int u, logic v, logic t, logic [3:0] idx);
      exp_t e;
      int   sz;
      sz = (u == 0) ? q0.size() :
           (u == 1) ? q1.size() : q2.size();
      chk($sformatf("pv%0d", u), v, sz != 0);
      if (sz != 0) begin
         case (u)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         chk($sformatf("pt%0d", u), t, e.t);
         chk($sformatf("pidx%0d", u), idx, e.idx);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      mon(0, pv[0], pt[0], pidx0);
      mon(1, pv[1], pt[1], pidx1);
      mon(2, pv[2], pt[2], {1'b0, pidx2});
      for (int i = 0; i < 3; i++) begin
         rv[i] = 1'b0;
         uv[i] = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rv[i]   = 1'b0;
         rpc[i]  = '0;
         uv[i]   = 1'b0;
         uidx[i] = '0;
         ut[i]   = 1'b0;
      end
      tick();
      tick();
      chk("rst_rdy", rdy[0], 0);
      chk("rst_pt", pt[0], 0);
      chk("rst_pidx", pidx0, 0);
      reset = 1'b0;

      // init: request at cycle 3 must be dropped
      for (int k = 1; k <= 16; k++) begin
         if (k == 3) begin
            rv[0]  = 1'b1;
            rpc[0] = 32'h0000_0014;
         end
         tick();
         chk($sformatf("init_rdy0_%0d", k), rdy[0], k == 16);
         chk($sformatf("init_rdy2_%0d", k), rdy[2], k >= 8);
      end

      // every entry starts strongly taken, back-to-back
      for (int i = 0; i < 16; i++) begin
         req(0, 32'(i) << 2, 1'b1, 4'(i));
         req(1, 32'(i) << 2, 1'b1, 4'(i));
         tick();
      end

      // saturation on bimodal entry 5
      for (int i = 0; i < 3; i++) begin
         upd(1, 4'd5, 1'b0);
         tick();
      end
      req(1, 32'h14, 1'b0, 4'd5);
      tick();
      upd(1, 4'd5, 1'b0);
      tick();
      upd(1, 4'd5, 1'b1);
      tick();
      req(1, 32'h14, 1'b0, 4'd5);
      tick();
      upd(1, 4'd5, 1'b1);
      tick();
      req(1, 32'h14, 1'b1, 4'd5);
      tick();
      for (int i = 0; i < 5; i++) begin
         upd(1, 4'd5, 1'b1);
         tick();
      end
      req(1, 32'h14, 1'b1, 4'd5);
      tick();

      // same-cycle read and update on entry 9 (at 10)
      upd(1, 4'd9, 1'b0);
      tick();
      upd(1, 4'd9, 1'b0);
      req(1, 32'h24, 1'b1, 4'd9);
      tick();
      req(1, 32'h24, 1'b0, 4'd9);
      tick();

      // gshare: history 1011, pc bits 0101 -> 1110
      upd(0, 4'd12, 1'b1);
      tick();
      upd(0, 4'd12, 1'b0);
      tick();
      upd(0, 4'd12, 1'b1);
      tick();
      upd(0, 4'd12, 1'b1);
      tick();
      req(0, 32'h14, 1'b1, 4'hE);
      req(1, 32'h14, 1'b1, 4'h5);
      tick();

      // wide counter entry 2: 111 -> 100 -> 011 -> 100
      for (int i = 0; i < 3; i++) begin
         upd(2, 4'd2, 1'b0);
         tick();
      end
      req(2, 32'h8, 1'b1, 4'd2);
      tick();
      upd(2, 4'd2, 1'b0);
      tick();
      req(2, 32'h8, 1'b0, 4'd2);
      tick();
      upd(2, 4'd2, 1'b1);
      tick();
      req(2, 32'h8, 1'b1, 4'd2);
      tick();

      // drain entry 3, leave history at 0001
      for (int i = 0; i < 4; i++) begin
         upd(0, 4'd3, 1'b0);
         tick();
      end
      upd(0, 4'd10, 1'b1);
      tick();
      req(0, 32'h0C, 1'b1, 4'd2);
      tick();
      req(0, 32'h08, 1'b0, 4'd3);
      tick();

      // reset mid-run: request in the reset cycle is dropped
      reset  = 1'b1;
      rv[0]  = 1'b1;
      rpc[0] = 32'h0C;
      tick();
      chk("rst2_rdy", rdy[0], 0);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("reinit_rdy_%0d", k), rdy[0], k == 16);
      end
      req(0, 32'h0C, 1'b1, 4'd3);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
